fp_mul_arbiter: RTL and testbench
=================================

# fp_mul_arbiter

Round-robin scheduler that shares one pipelined single-precision floating-point multiplier between NUM_REQ requesters (feature-extraction stages of the ASR datapath). It accepts at most one operand pair per cycle, drives the multiplier's operand inputs, and tracks in-flight tags so that each product is returned to the requester that issued it. The multiplier cannot stall, so responses have no backpressure.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, IEEE-754 single word width
- MUL_LATENCY, 2, multiplier register stages (input sample edge to result valid)
- TAG_WIDTH, 2, width of requester index; must satisfy 2^TAG_WIDTH >= NUM_REQ

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- arb_en  in  1  grant enable; low blocks new grants, in-flight ops still drain
- req_valid  in  NUM_REQ  per-requester operand pair valid
- req_a  in  NUM_REQ*DATA_WIDTH  packed operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  in  NUM_REQ*DATA_WIDTH  packed operand B, same packing
- req_ready  out  NUM_REQ  one-hot grant; accept when req_valid[i] & req_ready[i]
- mul_a  out  DATA_WIDTH  registered operand to multiplier factor 1
- mul_b  out  DATA_WIDTH  registered operand to multiplier factor 2
- mul_result  in  DATA_WIDTH  multiplier product
- rsp_valid  out  NUM_REQ  one-hot, product for requester i this cycle
- rsp_tag  out  TAG_WIDTH  index of requester owning rsp_data
- rsp_data  out  DATA_WIDTH  mul_result passed through
- idle  out  1  no op in flight and no accept this cycle
- op_count  out  16  total accepted ops since reset, wraps

## Operation

- Grant (combinational): when arb_en=1, req_ready = one-hot of first set req_valid bit searching from (last_grant+1) mod NUM_REQ upward, wrapping. req_ready = 0 when arb_en=0 or no req_valid. req_ready never asserted without the matching req_valid.
- On accept edge: mul_a/mul_b <= granted req_a/req_b; last_grant <= granted index; tag pipeline slot 0 <= {1, index}; op_count <= op_count+1 (0xFFFF -> 0x0000).
- No accept: mul_a/mul_b hold previous values; slot 0 <= {0, 0}.
- Tag pipeline: MUL_LATENCY+1 slots {valid, tag}, shifts every cycle unconditionally.
- Response: rsp_valid = slot[MUL_LATENCY].valid ? one-hot(slot tag) : 0; rsp_tag = slot tag (0 when invalid); rsp_data = mul_result always.
- idle = no slot valid and no accept this cycle.
- Requesters must accept rsp_valid in the cycle it is asserted; a dropped response is a requester error, not detected here.
- Zero operands, signs and exponent handling are the multiplier's job; arbiter is data-transparent.

## Timing

- Reset values: req_ready=0 (combinational, arb_en-dependent), mul_a=0, mul_b=0, all tag slots invalid, last_grant=NUM_REQ-1 (requester 0 has top priority first), rsp_valid=0, rsp_tag=0, op_count=0, idle=1.
- Accept at edge E -> mul_a/mul_b valid after E -> product valid after E+MUL_LATENCY+... aligned so rsp_valid asserted in the cycle after edge E+MUL_LATENCY; accept-to-response latency MUL_LATENCY+1 cycles (3 by default).
- Throughput: one op per cycle sustained; back-to-back responses keep issue order.
- Single requester continuously valid: granted every cycle (round-robin finds only it).
- All requesters valid: grants rotate 0,1,2,3,0,... one per cycle.
- arb_en falling: no accept from that cycle; in-flight ops complete with normal latency. arb_en rising: arbitration resumes from stored last_grant.
- req_valid dropped without accept: no state change, no penalty.
- Reset mid-operation: in-flight tags cleared immediately, no rsp_valid for them after release; multiplier shares rst_n.

## Test plan

- Reset release, arb_en=1, requester 0 sends 0x40000000 x 0x40400000 -> req_ready=0001 same cycle, rsp_valid=0001, rsp_tag=0, rsp_data=0x40C00000 exactly 3 cycles later; op_count=1; idle returns 1.
- All four valid for 8 cycles with distinct operands (requester i: 1.5 x 1.5 = 0x40100000 for i=2) -> grant order 0,1,2,3,0,1,2,3; responses same order, each tag matches its product.
- Requesters 1 and 3 only, continuously -> grants alternate 1,3,1,3; never 0 or 2.
- arb_en low while 2 ops in flight and all requesters valid -> req_ready=0, both responses still delivered at 3-cycle latency, idle rises after drain; re-enable resumes after last_grant.
- Assert rst_n low one cycle after an accept -> no rsp_valid ever for that op; all outputs at reset values during and after reset.
- Preload via 65536 accepts -> op_count wraps 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/fp_mul_arbiter_if.sv
// fp_mul_arbiter_if: requester, multiplier and response signals of the shared multiplier arbiter
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2
);
  logic                          arb_en;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         mul_a;
  logic [DATA_WIDTH-1:0]         mul_b;
  logic [DATA_WIDTH-1:0]         mul_result;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [TAG_WIDTH-1:0]          rsp_tag;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          idle;
  logic [15:0]                   op_count;
  modport master (
    output arb_en, req_valid, req_a, req_b, mul_result,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_tag, rsp_data, idle, op_count
  );
  modport slave (
    input  arb_en, req_valid, req_a, req_b, mul_result,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_tag, rsp_data, idle, op_count
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one pipelined fp multiplier with tag tracking for response routing
module fp_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 2,
  parameter int TAG_WIDTH   = 2
) (
  input logic             clk,
  input logic             rst_n,
  fp_mul_arbiter_if.slave bus
);
  logic [TAG_WIDTH-1:0]                  last_grant;
  logic [TAG_WIDTH-1:0]                  gnt_idx;
  logic [TAG_WIDTH-1:0]                  cand;
  logic                                  accept;
  logic [DATA_WIDTH-1:0]                 sel_a;
  logic [DATA_WIDTH-1:0]                 sel_b;
  logic [MUL_LATENCY:0]                  slot_v;
  logic [MUL_LATENCY:0][TAG_WIDTH-1:0]   slot_t;
  // first valid requester searching upward from the one after the last grant
  always_comb begin
    accept = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = TAG_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      if (!accept && bus.arb_en && bus.req_valid[cand]) begin
        accept = 1'b1;
        gnt_idx = cand;
      end
    end
  end
  // operand mux for the granted requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_idx == TAG_WIDTH'(i)) begin
        sel_a = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  // operand registers, grant pointer, in-flight tag pipeline and op counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.mul_a <= '0;
      bus.mul_b <= '0;
      last_grant <= TAG_WIDTH'(NUM_REQ - 1);
      slot_v <= '0;
      slot_t <= '0;
      bus.op_count <= '0;
    end else begin
      slot_v <= {slot_v[MUL_LATENCY-1:0], accept};
      slot_t <= {slot_t[MUL_LATENCY-1:0], accept ? gnt_idx : TAG_WIDTH'(0)};
      if (accept) begin
        bus.mul_a <= sel_a;
        bus.mul_b <= sel_b;
        last_grant <= gnt_idx;
        bus.op_count <= bus.op_count + 16'd1;
      end
    end
  assign bus.req_ready = accept ? NUM_REQ'(1) << gnt_idx : '0;
  assign bus.rsp_valid = slot_v[MUL_LATENCY] ? NUM_REQ'(1) << slot_t[MUL_LATENCY] : '0;
  assign bus.rsp_tag   = slot_v[MUL_LATENCY] ? slot_t[MUL_LATENCY] : '0;
  assign bus.rsp_data  = bus.mul_result;
  assign bus.idle      = ~|slot_v & ~accept;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: randomized and directed checks of the multiplier arbiter against a queue-based reference
module tb_fp_mul_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  fp_mul_arbiter_if bus ();
  fp_mul_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    int e;
    p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) return {x[31] ^ y[31], 8'(e + 1), p[46:24]};
    return {x[31] ^ y[31], 8'(e), p[45:23]};
  endfunction
  logic [31:0] p1, p2;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= fmul(bus.mul_a, bus.mul_b);
      p2 <= p1;
    end
  assign bus.mul_result = p2;
  typedef struct {int due; int tag; logic [31:0] data;} rsp_t;
  rsp_t q[$];
  int gnt_log[$];
  int m_last = 3;
  int m_cnt = 0;
  int cyc = 0;
  logic [31:0] a_op[4];
  logic [31:0] b_op[4];
  logic [31:0] last_rsp_data;
  int last_rsp_tag;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction
  task automatic step(input logic en, input logic [3:0] v);
    int g;
    bus.arb_en = en;
    bus.req_valid = v;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*32 +: 32] = a_op[i];
      bus.req_b[i*32 +: 32] = b_op[i];
    end
    #1;
    g = -1;
    if (en)
      for (int k = 1; k <= 4; k++)
        if (g < 0 && v[(m_last + k) % 4]) g = (m_last + k) % 4;
    chk("req_ready", 32'(bus.req_ready), g < 0 ? 32'd0 : 32'd1 << g);
    chk("idle", 32'(bus.idle), 32'(q.size() == 0 && g < 0));
    chk("op_count", 32'(bus.op_count), 32'(m_cnt));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << q[0].tag);
      chk("rsp_tag", 32'(bus.rsp_tag), 32'(q[0].tag));
      chk("rsp_data", bus.rsp_data, q[0].data);
      last_rsp_data = bus.rsp_data;
      last_rsp_tag = int'(bus.rsp_tag);
      void'(q.pop_front());
    end else begin
      chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
      chk("rsp_tag_idle", 32'(bus.rsp_tag), 32'd0);
    end
    gnt_log.push_back(g);
    if (g >= 0) begin
      q.push_back('{cyc + 3, g, fmul(a_op[g], b_op[g])});
      m_last = g;
      m_cnt = (m_cnt + 1) & 16'hFFFF;
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_mul_a"}, bus.mul_a, 32'd0);
    chk({tag, "_mul_b"}, bus.mul_b, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_tag"}, 32'(bus.rsp_tag), 32'd0);
    chk({tag, "_op_count"}, 32'(bus.op_count), 32'd0);
    chk({tag, "_idle"}, 32'(bus.idle), 32'd1);
  endtask
  task automatic do_reset();
    bus.req_valid = '0;
    bus.arb_en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    q.delete();
    m_last = 3;
    m_cnt = 0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      a_op[i] = rnd_fp();
      b_op[i] = rnd_fp();
    end
    bus.req_a = '0;
    bus.req_b = '0;
    @(negedge clk);
    do_reset();
    a_op[0] = 32'h40000000;
    b_op[0] = 32'h40400000;
    step(1'b1, 4'b0001);
    chk("t1_grant", 32'(gnt_log[$]), 32'd0);
    repeat (3) step(1'b1, 4'b0000);
    chk("t1_data", last_rsp_data, 32'h40C00000);
    chk("t1_tag", 32'(last_rsp_tag), 32'd0);
    chk("t1_count", 32'(bus.op_count), 32'd1);
    chk("t1_idle", 32'(bus.idle), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_op[i] = rnd_fp();
      b_op[i] = rnd_fp();
    end
    a_op[2] = 32'h3FC00000;
    b_op[2] = 32'h3FC00000;
    gnt_log.delete();
    repeat (8) step(1'b1, 4'b1111);
    for (int k = 0; k < 8; k++) chk("rr_all", 32'(gnt_log[k]), 32'(k % 4));
    repeat (3) step(1'b1, 4'b0000);
    chk("rr_last_tag", 32'(last_rsp_tag), 32'd3);
    chk("mul_2_fixed", fmul(a_op[2], b_op[2]), 32'h40100000);
    do_reset();
    gnt_log.delete();
    repeat (8) step(1'b1, 4'b1010);
    for (int k = 0; k < 8; k++) chk("rr_13", 32'(gnt_log[k]), k % 2 == 0 ? 32'd1 : 32'd3);
    repeat (4) step(1'b1, 4'b0000);
    do_reset();
    gnt_log.delete();
    repeat (2) step(1'b1, 4'b1111);
    repeat (5) step(1'b0, 4'b1111);
    chk("drain_idle", 32'(bus.idle), 32'd1);
    step(1'b1, 4'b1111);
    chk("resume_grant", 32'(gnt_log[$]), 32'd2);
    repeat (4) step(1'b1, 4'b0000);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        a_op[i] = rnd_fp();
        b_op[i] = rnd_fp();
      end
      step($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)));
    end
    repeat (4) step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);
    do_reset();
    repeat (6) step(1'b1, 4'b0000);
    do_reset();
    repeat (65535) step(1'b1, 4'b0100);
    chk("wrap_ffff", 32'(bus.op_count), 32'h0000FFFF);
    step(1'b1, 4'b0100);
    chk("wrap_0000", 32'(bus.op_count), 32'h00000000);
    repeat (4) step(1'b1, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
